// File: rtl/tx_msg_streamer.sv
// Streams "current state:<label>  rate:<digits>\n" as ASCII bytes to a UART.
// The rate is converted to BCD serially (one bit per cycle) before sending starts.
module tx_msg_streamer #(
  parameter int RATE_W      = 8,
  parameter int RATE_DIGITS = 3,
  parameter int LABEL_LEN   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSTART,
  input  logic [1:0]        iMODE,
  input  logic [RATE_W-1:0] iRATE,
  input  logic              iFINISH,
  output logic [7:0]        oTX_DATA,
  output logic              oTX_VALID,
  input  logic              iTX_READY,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int MSG_LEN = 22 + LABEL_LEN + RATE_DIGITS;
  localparam int IDX_W   = $clog2(MSG_LEN);
  localparam int DIG_OFS = 21 + LABEL_LEN;
  localparam int unsigned MAX_RATE = 10**RATE_DIGITS - 1;

  localparam logic [8*14-1:0] PREFIX   = "current state:";
  localparam logic [8*7-1:0]  MID      = "  rate:";
  localparam logic [95:0]     LBL_INIT = "initial     ";
  localparam logic [95:0]     LBL_NORM = "normal      ";
  localparam logic [95:0]     LBL_RATE = "rate control";
  localparam logic [95:0]     LBL_NONE = "            ";

  localparam logic [4:0]       CONV_LAST = 5'(RATE_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              sat_q, sat_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic        accept, last;
  logic [19:0] adj;
  logic [95:0] lbl;
  logic [RATE_DIGITS-1:0][7:0] dig_chr;
  logic [MSG_LEN-1:0][7:0]     msg;

  assign accept = iSTART && (iMODE != 2'd3);
  assign last   = (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      rate_q  <= '0;
      sat_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      sat_q   <= sat_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CONV;
      S_CONV:  if (cnt_q == CONV_LAST) state_d = S_SEND;
      S_SEND:  if (iTX_READY && last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (iFINISH) state_d = S_IDLE;
  end

  // Shift-add-3: correct each BCD digit before shifting in the next rate bit.
  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                     : bcd_q[4*g +: 4];
  end

  always_comb begin
    mode_d = mode_q;
    rate_d = rate_q;
    sat_d  = sat_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    case (state_q)
      S_IDLE: if (accept) begin
        mode_d = iMODE;
        rate_d = iRATE;
        sat_d  = (32'(iRATE) > MAX_RATE);
        bcd_d  = '0;
        cnt_d  = '0;
      end
      S_CONV: begin
        bcd_d = 20'({adj, rate_q[RATE_W-1]});
        rate_d = rate_q << 1;
        cnt_d  = cnt_q + 5'd1;
        idx_d  = '0;
      end
      S_SEND:  if (iTX_READY && !last) idx_d = idx_q + 1'b1;
      default: idx_d = '0;
    endcase
    if (iFINISH) idx_d = '0;
  end

  always_comb begin
    case (mode_q)
      2'd0:    lbl = LBL_INIT;
      2'd1:    lbl = LBL_NORM;
      2'd2:    lbl = LBL_RATE;
      default: lbl = LBL_NONE;
    endcase
  end

  // Digit g is blank only if it and every more-significant digit are zero.
  for (genvar g = 0; g < RATE_DIGITS; g++) begin : g_dig
    logic lead;
    if (g == 0) begin : g_lsd
      assign lead = 1'b1;
    end else begin : g_hi
      assign lead = |bcd_q[4*RATE_DIGITS-1 : 4*g];
    end
    assign dig_chr[g] = sat_q ? 8'h39 : (lead ? {4'h3, bcd_q[4*g +: 4]} : 8'h20);
  end

  for (genvar g = 0; g < 14; g++) begin : g_pre
    assign msg[g] = PREFIX[8*(13-g) +: 8];
  end
  for (genvar g = 0; g < LABEL_LEN; g++) begin : g_lbl
    if (g < 12) begin : g_chr
      assign msg[14+g] = lbl[8*(11-g) +: 8];
    end else begin : g_pad
      assign msg[14+g] = 8'h20;
    end
  end
  for (genvar g = 0; g < 7; g++) begin : g_mid
    assign msg[14+LABEL_LEN+g] = MID[8*(6-g) +: 8];
  end
  for (genvar g = 0; g < RATE_DIGITS; g++) begin : g_rate
    assign msg[DIG_OFS+g] = dig_chr[RATE_DIGITS-1-g];
  end
  assign msg[MSG_LEN-1] = 8'h0A;

  always_comb begin
    oTX_VALID = (state_q == S_SEND);
    oTX_DATA  = oTX_VALID ? msg[idx_q] : 8'hFF;
    oBUSY     = (state_q != S_IDLE);
    oDONE     = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_tx_msg_streamer.sv
// Bench for tx_msg_streamer: message-level model plus literal message checks.
module tb_tx_msg_streamer;
  localparam int RW = 8, RD = 3, LL = 12;

  logic clk = 1'b0;
  logic reset, iSTART, iFINISH, iTX_READY;
  logic [1:0]    iMODE;
  logic [RW-1:0] iRATE;
  logic [7:0] oTX_DATA, d2;
  logic oTX_VALID, oBUSY, oDONE, v2, b2, dn2;

  always #5 clk = ~clk;

  tx_msg_streamer #(.RATE_W(RW), .RATE_DIGITS(RD), .LABEL_LEN(LL)) dut (
    .clk(clk), .reset(reset), .iSTART(iSTART), .iMODE(iMODE), .iRATE(iRATE),
    .iFINISH(iFINISH), .oTX_DATA(oTX_DATA), .oTX_VALID(oTX_VALID),
    .iTX_READY(iTX_READY), .oBUSY(oBUSY), .oDONE(oDONE));

  tx_msg_streamer #(.RATE_W(RW), .RATE_DIGITS(2), .LABEL_LEN(LL)) dut2 (
    .clk(clk), .reset(reset), .iSTART(iSTART), .iMODE(iMODE), .iRATE(iRATE),
    .iFINISH(iFINISH), .oTX_DATA(d2), .oTX_VALID(v2),
    .iTX_READY(iTX_READY), .oBUSY(b2), .oDONE(dn2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic string build(input int m, input int r, input int d, input int l);
    string lbl, dg;
    int v;
    bit lead;
    case (m)
      0:       lbl = "initial";
      1:       lbl = "normal";
      default: lbl = "rate control";
    endcase
    while (lbl.len() < l) lbl = {lbl, " "};
    if (lbl.len() > l) lbl = lbl.substr(0, l - 1);
    dg = "";
    lead = 1'b1;
    if (r > 10**d - 1) begin
      for (int p = 0; p < d; p++) dg = {dg, "9"};
    end else begin
      for (int p = d - 1; p >= 0; p--) begin
        v = (r / 10**p) % 10;
        if (v != 0 || p == 0) lead = 1'b0;
        if (lead) dg = {dg, " "};
        else      dg = {dg, $sformatf("%0d", v)};
      end
    end
    return {"current state:", lbl, "  rate:", dg, "\n"};
  endfunction

  // Model: phase 0 idle, 1 converting, 2 sending, 3 done.
  int    m_phase = 0, m_wait = 0, m_ptr = 0;
  string m_msg = "";
  byte   rx[$], rx2[$];
  int    xfers = 0, dones = 0;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_data;
  int    exp_d;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset valid", int'(oTX_VALID), 0);
      chk("reset data", int'(oTX_DATA), 255);
      chk("reset busy", int'(oBUSY), 0);
      chk("reset done", int'(oDONE), 0);
      m_phase = 0;
      prev_stall = 1'b0;
    end else begin
      exp_d = (m_phase == 2) ? (int'(m_msg[m_ptr]) & 255) : 255;
      chk("valid", int'(oTX_VALID), int'(m_phase == 2));
      chk("data", int'(oTX_DATA), exp_d);
      chk("busy", int'(oBUSY), int'(m_phase != 0));
      chk("done", int'(oDONE), int'(m_phase == 3));
      if (prev_stall && oTX_VALID === 1'b1) chk("hold data", int'(oTX_DATA), int'(prev_data));
      prev_stall = (oTX_VALID === 1'b1) && !iTX_READY;
      prev_data  = oTX_DATA;
      if (oTX_VALID === 1'b1 && iTX_READY) begin rx.push_back(oTX_DATA); xfers++; end
      if (oDONE === 1'b1) dones++;
      if (v2 === 1'b1 && iTX_READY) rx2.push_back(d2);
      if (iFINISH) m_phase = 0;
      else case (m_phase)
        0: if (iSTART && iMODE != 2'd3) begin
          m_msg = build(int'(iMODE), int'(iRATE), RD, LL);
          m_phase = 1;
          m_wait = RW;
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin m_phase = 2; m_ptr = 0; end
        end
        2: if (iTX_READY) begin
          if (m_ptr == m_msg.len() - 1) m_phase = 3;
          else m_ptr++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int m, input int r);
    @(posedge clk); #1;
    iSTART = 1'b1; iMODE = 2'(m); iRATE = RW'(r);
    @(posedge clk); #1;
    iSTART = 1'b0;
  endtask

  task automatic run_msg(input bit rnd);
    int d0, c;
    d0 = dones;
    c = 0;
    while (dones == d0 && c < 2000) begin
      @(posedge clk); #1;
      iTX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
    iTX_READY = 1'b1;
    chk("message completes with one done", dones - d0, 1);
  endtask

  task automatic chk_rx(input string nm, input string lit, input bit second);
    byte q[$];
    int bad;
    q = second ? rx2 : rx;
    bad = 0;
    chk({nm, " length"}, q.size(), lit.len());
    for (int i = 0; i < q.size() && i < lit.len(); i++)
      if (q[i] != lit[i]) bad++;
    chk({nm, " byte errors"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string lit1, lit2, lit3, lit4;
    int x0, d0, c;
    lit1 = "current state:normal        rate: 50\n";
    lit2 = "current state:rate control  rate:255\n";
    lit3 = "current state:initial       rate:  7\n";
    lit4 = "current state:rate control  rate:99\n";
    reset = 1'b0; iSTART = 1'b0; iFINISH = 1'b0; iTX_READY = 1'b1;
    iMODE = 2'd0; iRATE = '0;
    #2;
    chk("por valid", int'(oTX_VALID), 0);
    chk("por data", int'(oTX_DATA), 255);
    wait_cyc(3);
    reset = 1'b1;

    // Basic message, ready held high, plus model pinned to literals
    chk("model pin normal/50", int'(build(1, 50, 3, 12) == lit1), 1);
    chk("model pin rate/255 2dig", int'(build(2, 255, 2, 12) == lit4), 1);
    rx.delete();
    start(1, 50);
    run_msg(1'b0);
    chk_rx("normal/50", lit1, 1'b0);

    rx.delete(); rx2.delete();
    start(2, 255);
    run_msg(1'b0);
    chk_rx("rate/255", lit2, 1'b0);
    chk_rx("rate/255 two digits", lit4, 1'b1);

    rx.delete();
    start(0, 7);
    run_msg(1'b0);
    chk_rx("initial/7", lit3, 1'b0);

    // Random backpressure
    rx.delete();
    start(1, 50);
    run_msg(1'b1);
    chk_rx("normal/50 backpressure", lit1, 1'b0);

    // Abort at the 10th byte, then a clean message
    rx.delete();
    start(1, 50);
    x0 = xfers; c = 0;
    while (xfers - x0 < 9 && c < 500) begin @(posedge clk); #1; c++; end
    chk("transfers before abort", xfers - x0, 9);
    iFINISH = 1'b1;
    @(posedge clk); #1;
    iFINISH = 1'b0;
    chk("abort valid", int'(oTX_VALID), 0);
    chk("abort data", int'(oTX_DATA), 255);
    chk("abort busy", int'(oBUSY), 0);
    d0 = dones;
    wait_cyc(20);
    chk("abort no done", dones - d0, 0);
    rx.delete();
    start(1, 50);
    run_msg(1'b0);
    chk_rx("after abort", lit1, 1'b0);

    // Reserved mode ignored
    x0 = xfers;
    start(3, 50);
    wait_cyc(40);
    chk("mode3 no transfers", xfers - x0, 0);
    chk("mode3 idle", int'(oBUSY), 0);

    // Start during SEND and rate/mode changes mid-message
    rx.delete();
    start(1, 50);
    wait_cyc(12);
    iSTART = 1'b1; iMODE = 2'd0; iRATE = 8'd200;
    @(posedge clk); #1;
    iSTART = 1'b0;
    run_msg(1'b0);
    chk_rx("mid-message changes", lit1, 1'b0);
    x0 = xfers;
    wait_cyc(40);
    chk("start not queued", xfers - x0, 0);

    // Asynchronous reset during SEND
    start(0, 7);
    wait_cyc(13);
    chk("in send before reset", int'(oTX_VALID), 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async reset valid", int'(oTX_VALID), 0);
    chk("async reset data", int'(oTX_DATA), 255);
    chk("async reset busy", int'(oBUSY), 0);
    chk("async reset done", int'(oDONE), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    x0 = xfers;
    wait_cyc(30);
    chk("after reset no transfers", xfers - x0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
